uart_tx_data_path: RTL
======================

# uart_tx_data_path

Serial transmitter for the UART+CRC link, the transmitting counterpart of the receive data path. It accepts one byte per valid/ready handshake and serializes a frame of start bit, 8 data bits LSB first, even parity, an optional 8-bit CRC, and a stop bit. Bit boundaries are paced by an external baud tick (`trigger_i`). The block sits between the host-side byte source and the TX pin.

## Interface
- No parameters.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `trigger_i`  in  1  baud tick; one-`clk_i`-cycle pulse per bit time.
- `data_i`  in  8  byte to send; sampled on acceptance.
- `valid_i`  in  1  byte available.
- `ready_o`  out  1  block can accept a byte; high only in IDLE.
- `crc_en_i`  in  1  send a CRC field in this frame; sampled on acceptance (present only with `UART_TX_CRC_EN`).
- `tx_o`  out  1  serial line, registered; idle high.
- `busy_o`  out  1  frame in progress (any state other than IDLE).
- `done_o`  out  1  one-cycle pulse when the stop bit completes.

## Operation
- **States:** IDLE, ARMED, START, DATA, PARITY, CRC, STOP.
- **IDLE:**
  - `ready_o`=1 and `tx_o`=1.
  - On `valid_i & ready_o`, latch the following, then go to ARMED:
    - `data_i` into the shift register;
    - parity = `^data_i` (even parity);
    - the CRC of `data_i`;
    - `crc_en_i`.
  - A `trigger_i` in the acceptance cycle is ignored.
- **ARMED:** on `trigger_i`, drive `tx_o`=0 and go to START.
- **START:** on `trigger_i`, drive data bit 0 and go to DATA with bit counter (5 bit) = 0.
- **DATA:** on each `trigger_i`:
  - if counter < 7, increment the counter and drive the next data bit (LSB first);
  - at counter = 7, drive parity, go to PARITY, clear the counter.
- **PARITY:** on `trigger_i`:
  - if CRC is latched enabled, drive CRC bit 0 and go to CRC;
  - else drive `tx_o`=1 and go to STOP.
- **CRC:** same scheme as DATA (CRC sent LSB first). At counter = 7, drive `tx_o`=1 and go to STOP.
- **STOP:** on `trigger_i`, go to IDLE, pulse `done_o`, keep `tx_o`=1.
- **CRC definition:**
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Input is the data byte processed MSB first.
  - Computed combinationally from `data_i` at acceptance and stored in an 8-bit register.
- **Ignored inputs:**
  - `valid_i` while `ready_o`=0 is ignored; no byte is queued.
  - `data_i` and `crc_en_i` changes after acceptance have no effect on the frame in flight.
- **Reset mid-frame:** immediate IDLE, `tx_o`=1, frame abandoned, no `done_o`.

## Timing
- **Reset values:**
  - `tx_o`=1, `ready_o`=1, `busy_o`=0, `done_o`=0;
  - state IDLE, all internal registers 0.
- All state and `tx_o` changes occur on the `clk_i` edge where `trigger_i`=1 is sampled. The new value is visible from the following cycle.
- **Start-bit latency:** `tx_o` falls on the first `trigger_i` strictly after the acceptance cycle. Each bit then lasts exactly one tick period.
- **Frame length:**
  - 19 bit times with CRC (1+8+1+8+1);
  - 11 bit times without CRC.
- **ready_o / busy_o timing:**
  - `ready_o` drops the cycle after acceptance.
  - `ready_o` rises in the same cycle `done_o` is high.
  - `busy_o` = !`ready_o`.
- **Back-to-back frames:** a byte accepted in the `done_o` cycle starts its start bit on the next tick. The minimum inter-frame gap is therefore one stop bit plus ARMED wait.
- `trigger_i` held high for consecutive cycles advances one bit per cycle. Conformance is not required; no protection is provided.

## Configuration
- **`UART_TX_CRC_EN` defined:**
  - `crc_en_i` port exists;
  - CRC register and CRC state are compiled in;
  - frame includes CRC when `crc_en_i`=1 at acceptance.
- **`UART_TX_CRC_EN` undefined:**
  - no `crc_en_i` port, no CRC logic;
  - PARITY always goes to STOP;
  - frames are always 11 bits.

## Test plan
- **Reset:** assert `rst_i` mid-DATA. Required: `tx_o`=1 and `ready_o`=1 asynchronously, with no `done_o`. The next frame is correct.
- **CRC frame:** send 0x01 with `crc_en_i`=1. Required per tick `tx_o` sequence: 0, 1,0,0,0,0,0,0,0, 1 (parity), 1,1,1,0,0,0,0,0 (CRC 0x07), 1. `done_o` pulses once, 19 ticks after the start bit begins.
- **Plain frame:** send 0xA5 with `crc_en_i`=0. Required: 0, 1,0,1,0,0,1,0,1, 0 (parity), 1, then `done_o`.
- **CRC value:** send 0xFF with CRC. Required: CRC field 0xF3, LSB first 1,1,0,0,1,1,1,1; parity 0.
- **Handshake:**
  - `valid_i` held high with changing `data_i` during a frame: only the accepted byte is sent.
  - Second byte accepted in the `done_o` cycle: its start bit appears on the next tick.
- **Tick alignment:** `valid_i` and `trigger_i` in the same cycle: the start bit begins on the following tick, not that one. With tick period 16 clk, each bit lasts exactly 16 cycles.

Source files
------------

// File: rtl/uart_tx_data_path.sv
// UART+CRC link transmitter: start, 8 data bits LSB first, even parity, optional CRC-8, stop.
// Define UART_TX_CRC_EN to compile in the crc_en_i port and the CRC field.
module uart_tx_data_path (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       trigger_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
`ifdef UART_TX_CRC_EN
  input  logic       crc_en_i,
`endif
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    IDLE, ARMED, START, DATA, PARITY,
`ifdef UART_TX_CRC_EN
    CRC,
`endif
    STOP
  } state_t;

  state_t      state, state_nxt;
  logic        tx_nxt, done_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [7:0]  sreg;
  logic        par;
  logic        load, shift_dat;

`ifdef UART_TX_CRC_EN
  logic [7:0]  crc_q;
  logic        crc_en_q;
  logic        shift_crc;

  // CRC-8 poly 0x07, init 0, byte fed MSB first, no reflection/xorout
  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

  assign ready_o = (state == IDLE);
  assign busy_o  = !ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_nxt    = tx_o;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    load      = 1'b0;
    shift_dat = 1'b0;
`ifdef UART_TX_CRC_EN
    shift_crc = 1'b0;
`endif
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        // a tick in the acceptance cycle is deliberately not consumed
        if (valid_i && ready_o) begin
          load      = 1'b1;
          state_nxt = ARMED;
        end
      end
      ARMED: if (trigger_i) begin
        tx_nxt    = 1'b0;
        state_nxt = START;
      end
      START: if (trigger_i) begin
        tx_nxt    = sreg[0];
        shift_dat = 1'b1;
        cnt_nxt   = 5'd0;
        state_nxt = DATA;
      end
      DATA: if (trigger_i) begin
        if (cnt < 5'd7) begin
          cnt_nxt   = cnt + 5'd1;
          tx_nxt    = sreg[0];
          shift_dat = 1'b1;
        end else begin
          cnt_nxt   = 5'd0;
          tx_nxt    = par;
          state_nxt = PARITY;
        end
      end
      PARITY: if (trigger_i) begin
`ifdef UART_TX_CRC_EN
        if (crc_en_q) begin
          tx_nxt    = crc_q[0];
          shift_crc = 1'b1;
          cnt_nxt   = 5'd0;
          state_nxt = CRC;
        end else begin
          tx_nxt    = 1'b1;
          state_nxt = STOP;
        end
`else
        tx_nxt    = 1'b1;
        state_nxt = STOP;
`endif
      end
`ifdef UART_TX_CRC_EN
      CRC: if (trigger_i) begin
        if (cnt < 5'd7) begin
          cnt_nxt   = cnt + 5'd1;
          tx_nxt    = crc_q[0];
          shift_crc = 1'b1;
        end else begin
          cnt_nxt   = 5'd0;
          tx_nxt    = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: if (trigger_i) begin
        tx_nxt    = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_o     <= 1'b1;
      done_o   <= 1'b0;
      cnt      <= 5'd0;
      sreg     <= 8'd0;
      par      <= 1'b0;
`ifdef UART_TX_CRC_EN
      crc_q    <= 8'd0;
      crc_en_q <= 1'b0;
`endif
    end else begin
      tx_o   <= tx_nxt;
      done_o <= done_nxt;
      cnt    <= cnt_nxt;
      if (load) begin
        sreg <= data_i;
        par  <= ^data_i;
      end else if (shift_dat) begin
        sreg <= {1'b0, sreg[7:1]};
      end
`ifdef UART_TX_CRC_EN
      if (load) begin
        crc_q    <= crc8(data_i);
        crc_en_q <= crc_en_i;
      end else if (shift_crc) begin
        crc_q <= {1'b0, crc_q[7:1]};
      end
`endif
    end
  end

endmodule
